// File: rtl/tcm_pkg.sv
// Shared constants and enumerations for the TCM data-port front end.
package tcm_pkg;

    localparam int TCM_ADDR_W = 14;
    localparam int TCM_WORDS  = 16384;
    localparam int TAG_W      = 11;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        RSP_RAM  = 1'b0,
        RSP_ZERO = 1'b1
    } rsp_sel_e;

endpackage

// File: rtl/tcm_dport_if.sv
// Core data-memory request/ack bus between the core (master) and the TCM port (slave).
interface tcm_dport_if;
    import tcm_pkg::*;

    logic [31:0]      mem_d_addr_i;
    logic [31:0]      mem_d_data_wr_i;
    logic             mem_d_rd_i;
    logic [3:0]       mem_d_wr_i;
    logic             mem_d_cacheable_i;
    logic [TAG_W-1:0] mem_d_req_tag_i;
    logic             mem_d_invalidate_i;
    logic             mem_d_writeback_i;
    logic             mem_d_flush_i;
    logic [31:0]      mem_d_data_rd_o;
    logic             mem_d_accept_o;
    logic             mem_d_ack_o;
    logic             mem_d_error_o;
    logic [TAG_W-1:0] mem_d_resp_tag_o;

    modport master (
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
               mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
               mem_d_writeback_i, mem_d_flush_i,
        input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o,
               mem_d_error_o, mem_d_resp_tag_o
    );

    modport slave (
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
               mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
               mem_d_writeback_i, mem_d_flush_i,
        output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o,
               mem_d_error_o, mem_d_resp_tag_o
    );

endinterface

// File: rtl/tcm_dport.sv
// Core data-port front end for the 64KB TCM: boot-load ownership, range check,
// write strobes and a fixed one-cycle ack carrying the TCM's registered read data.
module tcm_dport
    import tcm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter bit          BOOT_LOAD = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    tcm_dport_if.slave            mem_d,
    output logic [TCM_ADDR_W-1:0] ram_addr_o,
    output logic [31:0]           ram_data_wr_o,
    output logic [3:0]            ram_wr_o,
    input  logic [31:0]           ram_data_rd_i,
    input  logic                  load_valid_i,
    input  logic [31:0]           load_addr_i,
    input  logic [31:0]           load_data_i,
    input  logic                  load_done_i,
    output logic                  run_o,
    output logic                  load_err_o,
    output logic [14:0]           load_count_o
);

    localparam logic [14:0] COUNT_MAX = 15'(TCM_WORDS);

    state_e           state_q, state_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    rsp_sel_e         sel_q, sel_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic             load_err_q, load_err_d;
    logic [14:0]      load_count_q, load_count_d;

    logic             core_rw;
    logic             core_req;
    logic             core_in_win;
    logic             load_in_win;
    logic             accept;
    logic             ack_out;
    logic             unused_bits;

    assign core_rw     = mem_d.mem_d_rd_i | (|mem_d.mem_d_wr_i);
    assign core_req    = core_rw | mem_d.mem_d_invalidate_i |
                         mem_d.mem_d_writeback_i | mem_d.mem_d_flush_i;
    // The 64KB window is exactly one aligned 64KB page, so only the upper half matters.
    assign core_in_win = (mem_d.mem_d_addr_i[31:16] == BASE_ADDR[31:16]);
    assign load_in_win = (load_addr_i[31:16] == BASE_ADDR[31:16]);

    always_comb begin
        state_d       = state_q;
        load_err_d    = load_err_q;
        load_count_d  = load_count_q;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        sel_d         = RSP_ZERO;
        resp_tag_d    = resp_tag_q;
        accept        = 1'b0;
        ram_addr_o    = mem_d.mem_d_addr_i[15:2];
        ram_data_wr_o = mem_d.mem_d_data_wr_i;
        ram_wr_o      = 4'h0;

        case (state_q)
            LOAD: begin
                ram_addr_o    = load_addr_i[15:2];
                ram_data_wr_o = load_data_i;
                if (load_valid_i) begin
                    if (load_in_win) begin
                        ram_wr_o = 4'hF;
                        if (load_count_q != COUNT_MAX) begin
                            load_count_d = load_count_q + 15'd1;
                        end
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
                if (load_done_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                accept = 1'b1;
                if (core_req) begin
                    ack_d      = 1'b1;
                    resp_tag_d = mem_d.mem_d_req_tag_i;
                    if (core_rw && !core_in_win) begin
                        err_d = 1'b1;
                    end else if (core_rw) begin
                        // Writes return the pre-write word because the TCM is read-first.
                        sel_d    = RSP_RAM;
                        ram_wr_o = mem_d.mem_d_wr_i;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (rst_i) begin
            accept   = 1'b0;
            ram_wr_o = 4'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= BOOT_LOAD ? LOAD : RUN;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            sel_q        <= RSP_ZERO;
            resp_tag_q   <= '0;
            load_err_q   <= 1'b0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            sel_q        <= sel_d;
            resp_tag_q   <= resp_tag_d;
            load_err_q   <= load_err_d;
            load_count_q <= load_count_d;
        end
    end

    // A response still in flight when reset arrives is suppressed immediately.
    assign ack_out                = ack_q & ~rst_i;
    assign mem_d.mem_d_ack_o      = ack_out;
    assign mem_d.mem_d_error_o    = err_q & ack_out;
    assign mem_d.mem_d_resp_tag_o = resp_tag_q;
    assign mem_d.mem_d_data_rd_o  = (ack_out && (sel_q == RSP_RAM)) ? ram_data_rd_i : 32'h0;
    assign mem_d.mem_d_accept_o   = accept;

    assign run_o        = (state_q == RUN);
    assign load_err_o   = load_err_q;
    assign load_count_o = load_count_q;

    assign unused_bits = ^{mem_d.mem_d_cacheable_i, mem_d.mem_d_addr_i[1:0], load_addr_i[1:0]};

endmodule

// File: tb/tb_tcm_dport.sv
// Directed bench for tcm_dport with a read-first TCM stub and a request-level response model.
module tb_tcm_dport;
    import tcm_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcm_dport_if mem_d();

    logic [13:0] ram_addr;
    logic [31:0] ram_data_wr;
    logic [3:0]  ram_wr;
    logic [31:0] ram_rd;
    logic        load_valid;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        load_done;
    logic        run;
    logic        load_err;
    logic [14:0] load_count;

    tcm_dport #(.BASE_ADDR(BASE), .BOOT_LOAD(1'b1)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_d         (mem_d),
        .ram_addr_o    (ram_addr),
        .ram_data_wr_o (ram_data_wr),
        .ram_wr_o      (ram_wr),
        .ram_data_rd_i (ram_rd),
        .load_valid_i  (load_valid),
        .load_addr_i   (load_addr),
        .load_data_i   (load_data),
        .load_done_i   (load_done),
        .run_o         (run),
        .load_err_o    (load_err),
        .load_count_o  (load_count)
    );

    // Read-first TCM: registered read of the old word, byte-wise write.
    logic [31:0] tcm [0:16383];
    initial begin
        for (int i = 0; i < 16384; i++) tcm[i] = 32'h0;
        ram_rd = 32'h0;
    end
    always @(posedge clk) begin
        ram_rd <= tcm[ram_addr];
        for (int b = 0; b < 4; b++)
            if (ram_wr[b]) tcm[ram_addr][b*8 +: 8] <= ram_data_wr[b*8 +: 8];
    end

    typedef struct {
        int          due;
        logic [10:0] tag;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mmem [0:16383];
    logic        m_run;
    int          m_count;
    logic        m_err;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    initial for (int i = 0; i < 16384; i++) mmem[i] = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every cycle: either the oldest expected response is due, or no ack may appear.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            chk("ack_missing", 32'(exp_q[0].tag), 32'hFFFF_FFFF);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("ack",  32'(mem_d.mem_d_ack_o), 32'h1);
            chk("tag",  32'(mem_d.mem_d_resp_tag_o), 32'(exp_q[0].tag));
            chk("err",  32'(mem_d.mem_d_error_o), 32'(exp_q[0].err));
            chk("data", mem_d.mem_d_data_rd_o, exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            chk("no_ack",  32'(mem_d.mem_d_ack_o), 32'h0);
            chk("no_data", mem_d.mem_d_data_rd_o, 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_d.mem_d_addr_i       = 32'h0;
        mem_d.mem_d_data_wr_i    = 32'h0;
        mem_d.mem_d_rd_i         = 1'b0;
        mem_d.mem_d_wr_i         = 4'h0;
        mem_d.mem_d_cacheable_i  = 1'b0;
        mem_d.mem_d_req_tag_i    = 11'h0;
        mem_d.mem_d_invalidate_i = 1'b0;
        mem_d.mem_d_writeback_i  = 1'b0;
        mem_d.mem_d_flush_i      = 1'b0;
        load_valid = 1'b0;
        load_addr  = 32'h0;
        load_data  = 32'h0;
        load_done  = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_run   = 1'b0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data, input logic done);
        logic inwin;
        inwin      = (addr[31:16] == BASE[31:16]);
        load_valid = 1'b1;
        load_addr  = addr;
        load_data  = data;
        load_done  = done;
        #1;
        chk("load_ram_wr", 32'(ram_wr), inwin ? 32'hF : 32'h0);
        if (inwin) begin
            chk("load_ram_addr", 32'(ram_addr), 32'(addr[15:2]));
            mmem[addr[15:2]] = data;
            if (m_count < 16384) m_count++;
        end else begin
            m_err = 1'b1;
        end
        step();
        if (done) m_run = 1'b1;
        idle();
    endtask

    task automatic core(input logic [31:0] addr, input logic [31:0] wdata, input logic rd,
                        input logic [3:0] wr, input logic inv, input logic wb, input logic fl,
                        input logic [10:0] tag);
        logic rw, err;
        logic [13:0] idx;
        rsp_t r;
        rw  = rd || (wr != 4'h0);
        err = rw && (addr[31:16] != BASE[31:16]);
        idx = addr[15:2];
        mem_d.mem_d_addr_i       = addr;
        mem_d.mem_d_data_wr_i    = wdata;
        mem_d.mem_d_rd_i         = rd;
        mem_d.mem_d_wr_i         = wr;
        mem_d.mem_d_req_tag_i    = tag;
        mem_d.mem_d_invalidate_i = inv;
        mem_d.mem_d_writeback_i  = wb;
        mem_d.mem_d_flush_i      = fl;
        #1;
        if (m_run) begin
            chk("accept", 32'(mem_d.mem_d_accept_o), 32'h1);
            chk("run_ram_addr", 32'(ram_addr), 32'(idx));
            chk("run_ram_wr", 32'(ram_wr), err ? 32'h0 : 32'(wr));
            if (rw || inv || wb || fl) begin
                r.due  = cyc + 1;
                r.tag  = tag;
                r.err  = err;
                r.data = (rw && !err) ? mmem[idx] : 32'h0;
                exp_q.push_back(r);
            end
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (wr[b]) mmem[idx][b*8 +: 8] = wdata[b*8 +: 8];
        end
        step();
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_ack",      32'(mem_d.mem_d_ack_o), 32'h0);
        chk("rst_err",      32'(mem_d.mem_d_error_o), 32'h0);
        chk("rst_tag",      32'(mem_d.mem_d_resp_tag_o), 32'h0);
        chk("rst_data",     mem_d.mem_d_data_rd_o, 32'h0);
        chk("rst_accept",   32'(mem_d.mem_d_accept_o), 32'h0);
        chk("rst_run",      32'(run), 32'h0);
        chk("rst_load_err", 32'(load_err), 32'h0);
        chk("rst_count",    32'(load_count), 32'h0);
        chk("rst_ram_wr",   32'(ram_wr), 32'h0);
        rst = 1'b0;

        // Boot load
        load(BASE + 32'h0, 32'h1111_1111, 1'b0);
        load(BASE + 32'h4, 32'h2222_2222, 1'b0);
        chk("count_2",      32'(load_count), 32'd2);
        chk("load_run",     32'(run), 32'h0);
        chk("load_accept",  32'(mem_d.mem_d_accept_o), 32'h0);
        load(32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
        chk("load_err_set", 32'(load_err), 32'h1);
        chk("count_hold",   32'(load_count), 32'd2);
        step();
        chk("load_err_sticky", 32'(load_err), 32'h1);

        // Final load together with load_done; a core read that cycle is not accepted
        mem_d.mem_d_rd_i      = 1'b1;
        mem_d.mem_d_addr_i    = BASE;
        mem_d.mem_d_req_tag_i = 11'd9;
        #1;
        chk("transition_accept", 32'(mem_d.mem_d_accept_o), 32'h0);
        load(BASE + 32'h8, 32'h1234_5678, 1'b1);
        chk("run_after_done", 32'(run), 32'h1);
        chk("count_model",    32'(load_count), 32'(m_count));
        chk("count_3",        32'(load_count), 32'd3);
        chk("err_after_done", 32'(load_err), 32'(m_err));

        // RUN traffic
        core(BASE + 32'h4, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'd4);
        chk("rd4_data", mem_d.mem_d_data_rd_o, 32'h2222_2222);
        chk("rd4_tag",  32'(mem_d.mem_d_resp_tag_o), 32'd4);
        core(BASE + 32'h8, 32'hAABB_CCDD, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 11'd5);
        chk("wr_pre_data", mem_d.mem_d_data_rd_o, 32'h1234_5678);
        chk("wr_tag",      32'(mem_d.mem_d_resp_tag_o), 32'd5);
        core(BASE + 32'h8, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'd6);
        chk("merged_data", mem_d.mem_d_data_rd_o, 32'h1234_CCDD);
        core(32'h9000_0000, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'd7);
        chk("oob_err",  32'(mem_d.mem_d_error_o), 32'h1);
        chk("oob_data", mem_d.mem_d_data_rd_o, 32'h0);
        core(32'h9000_0000, 32'h5555_5555, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 11'd12);
        core(BASE + 32'hFFFC, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'd8);
        chk("edge_in_err", 32'(mem_d.mem_d_error_o), 32'h0);
        core(BASE + 32'h1_0000, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'd9);
        chk("edge_out_err", 32'(mem_d.mem_d_error_o), 32'h1);

        // Back-to-back read / flush / read
        core(BASE + 32'h0, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'd1);
        core(BASE + 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 11'd2);
        chk("flush_err",  32'(mem_d.mem_d_error_o), 32'h0);
        chk("flush_data", mem_d.mem_d_data_rd_o, 32'h0);
        core(BASE + 32'h4, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'd3);
        chk("b2b_tag3", 32'(mem_d.mem_d_resp_tag_o), 32'd3);

        // Write with rd set, then cache ops
        core(BASE + 32'hC, 32'hCAFE_F00D, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 11'd10);
        chk("rdwr_pre", mem_d.mem_d_data_rd_o, 32'h0);
        core(BASE + 32'hC, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'd11);
        chk("rdwr_post", mem_d.mem_d_data_rd_o, 32'hCAFE_F00D);
        core(32'h9000_0000, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 11'd12);
        core(BASE, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 11'd13);
        step();
        step();

        // Reset with a read in flight
        core(BASE + 32'h4, 32'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 11'd14);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_drop_ack", 32'(mem_d.mem_d_ack_o), 32'h0);
        step();
        chk("rst2_ack",   32'(mem_d.mem_d_ack_o), 32'h0);
        chk("rst2_run",   32'(run), 32'h0);
        chk("rst2_count", 32'(load_count), 32'h0);
        rst = 1'b0;
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
